// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Holds the FSM state encoding, payload limits and header packing.
package router_pkg;

    localparam int MAX_LEN = 63;
    localparam logic [1:0] BAD_ADDR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_CHECK
    } state_t;

    function automatic logic [7:0] hdr_pack(input logic [5:0] l, input logic [1:0] d);
        return {l, d};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: one synchronous write port, one zero-latency read port.
// Storage is not reset; contents are only read after being written.
module router_tx_buf
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:MAX_LEN];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-side transmitter: buffers one payload, then sends header, payload
// and parity under busy backpressure and reports the router's parity verdict.
module router_pkt_tx
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic       inject_err,
    input  logic       abort,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    input  logic       busy,
    input  logic       err,
    output logic       pkt_valid,
    output logic [7:0] pkt_data,
    output logic       idle,
    output logic       done,
    output logic       tx_err,
    output logic       bad_req
);

    state_t     state, state_nxt;
    logic [1:0] dest_q;
    logic [5:0] len_q;
    logic       inj_q;
    logic [5:0] idx;
    logic [7:0] parity;
    logic [1:0] cnt;
    logic       buf_we;
    logic [7:0] buf_rdata;
    logic       last;
    logic       start_bad;
    logic       start_ok;

    assign last      = (idx == len_q - 6'd1);
    assign start_bad = (len == 6'd0) || (dest == BAD_ADDR);
    assign start_ok  = start && !abort && !start_bad;

    router_tx_buf u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (idx),
        .wdata (src_data),
        .raddr (idx),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        src_ready = 1'b0;
        pkt_valid = 1'b0;
        pkt_data  = 8'd0;
        idle      = 1'b0;
        buf_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                idle = 1'b1;
                if (start_ok) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                src_ready = 1'b1;
                buf_we    = src_valid;
                if (src_valid && last) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                pkt_valid = 1'b1;
                pkt_data  = hdr_pack(len_q, dest_q);
                if (!busy) state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                pkt_valid = 1'b1;
                pkt_data  = buf_rdata;
                if (!busy && last) state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
                // Error injection flips only bit 0 so the router must flag it.
                pkt_data = parity ^ {7'd0, inj_q};
                if (!busy) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (cnt >= 2'd2 && !busy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            dest_q  <= 2'd0;
            len_q   <= 6'd0;
            inj_q   <= 1'b0;
            idx     <= 6'd0;
            parity  <= 8'd0;
            cnt     <= 2'd0;
            tx_err  <= 1'b0;
            done    <= 1'b0;
            bad_req <= 1'b0;
        end else begin
            done    <= 1'b0;
            bad_req <= 1'b0;
            cnt     <= 2'd0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (start_bad) begin
                            bad_req <= 1'b1;
                        end else begin
                            dest_q <= dest;
                            len_q  <= len;
                            inj_q  <= inject_err;
                            parity <= hdr_pack(len, dest);
                            tx_err <= 1'b0;
                            idx    <= 6'd0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (src_valid) begin
                        parity <= parity ^ src_data;
                        idx    <= last ? 6'd0 : idx + 6'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy && !last) idx <= idx + 6'd1;
                end
                ST_CHECK: begin
                    // Saturate: only "at least two cycles elapsed" matters.
                    cnt <= (cnt == 2'd3) ? cnt : cnt + 2'd1;
                    if (cnt >= 2'd2 && !busy && !abort) begin
                        tx_err <= err;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed and randomized checks of router_pkt_tx against a packet-level model:
// expected bus bytes are built from the payload list, then matched per cycle.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn, start, abort, inject_err, src_valid, busy, err;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] src_data;
    logic       src_ready, pkt_valid, idle, done, tx_err, bad_req;
    logic [7:0] pkt_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] pl[$];
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    router_pkt_tx dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .dest       (dest),
        .len        (len),
        .inject_err (inject_err),
        .abort      (abort),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .busy       (busy),
        .err        (err),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .idle       (idle),
        .done       (done),
        .tx_err     (tx_err),
        .bad_req    (bad_req)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill(input int l);
        pl.delete();
        for (int i = 0; i < l; i++) pl.push_back(8'($urandom_range(255)));
    endtask

    // Expected wire sequence: header, payload bytes, parity.
    task automatic do_start(input logic [1:0] d, input logic [5:0] l, input logic inj, input logic e);
        logic [7:0] p;
        exp_q.delete();
        p = {l, d};
        exp_q.push_back(p);
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            p = p ^ pl[i];
        end
        exp_q.push_back(p ^ {7'd0, inj});
        dest = d; len = l; inject_err = inj; err = e; start = 1'b1;
        step();
        start = 1'b0;
        chk("start_src_ready", {31'd0, src_ready}, 1);
        chk("start_idle", {31'd0, idle}, 0);
    endtask

    task automatic do_load(input int gap_mode);
        int  k = 0;
        int  g = 0;
        logic sv;
        while (k < pl.size() && g < 500) begin
            if (gap_mode == 0)      sv = 1'b1;
            else if (gap_mode == 1) sv = (g % 2 == 0);
            else                    sv = 1'($urandom_range(1));
            src_valid = sv;
            src_data  = sv ? pl[k] : 8'($urandom_range(255));
            busy      = 1'($urandom_range(1));
            step();
            if (sv) k++;
            g++;
        end
        src_valid = 1'b0;
        busy      = 1'b0;
        chk("load_count", k, pl.size());
        chk("hdr_valid", {31'd0, pkt_valid}, 1);
        chk("hdr_data", {24'd0, pkt_data}, {24'd0, exp_q[0]});
    endtask

    task automatic do_xmit(input int busy_pct, input int stall_n, input int stop_n, output int cycles);
        int   n = 0;
        int   stalls = 0;
        int   g = 0;
        logic b;
        while (n < stop_n && g < 2000) begin
            chk("bus_valid", {31'd0, pkt_valid}, {31'd0, n < pl.size() + 1});
            chk("bus_data", {24'd0, pkt_data}, {24'd0, exp_q[n]});
            b = (int'($urandom_range(99)) < busy_pct);
            if (n == stall_n && stalls < 2) begin
                b = 1'b1;
                stalls++;
            end
            busy = b;
            step();
            if (!b) n++;
            g++;
        end
        busy = 1'b0;
        chk("xmit_progress", n, stop_n);
        cycles = g;
    endtask

    task automatic do_check(input int busy_pct, input logic e, input logic exact);
        int c = 0;
        while (!done && c < 100) begin
            chk("check_valid", {31'd0, pkt_valid}, 0);
            chk("check_data", {24'd0, pkt_data}, 0);
            busy = (int'($urandom_range(99)) < busy_pct);
            step();
            c++;
        end
        busy = 1'b0;
        chk("done_pulse", {31'd0, done}, 1);
        chk("done_idle", {31'd0, idle}, 1);
        chk("tx_err", {31'd0, tx_err}, {31'd0, e});
        chk("check_min_cycles", {31'd0, c >= 3}, 1);
        if (exact) chk("check_cycles", c, 3);
        step();
        chk("done_once", {31'd0, done}, 0);
        chk("tx_err_hold", {31'd0, tx_err}, {31'd0, e});
    endtask

    task automatic run_pkt(input logic [1:0] d, input logic [5:0] l, input logic inj, input logic e,
                           input int gap_mode, input int busy_pct, input int stall_n);
        int cyc;
        do_start(d, l, inj, e);
        do_load(gap_mode);
        do_xmit(busy_pct, stall_n, int'(l) + 2, cyc);
        if (busy_pct == 0) chk("xmit_cycles", cyc, int'(l) + 2 + (stall_n >= 0 ? 2 : 0));
        do_check(busy_pct, e, busy_pct == 0);
    endtask

    initial begin
        int cyc;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; inject_err = 1'b0; src_valid = 1'b0;
        busy = 1'b0; err = 1'b0; dest = 2'd0; len = 6'd0; src_data = 8'd0;
        repeat (2) step();
        chk("rst_pkt_valid", {31'd0, pkt_valid}, 0);
        chk("rst_pkt_data", {24'd0, pkt_data}, 0);
        chk("rst_src_ready", {31'd0, src_ready}, 0);
        chk("rst_idle", {31'd0, idle}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_tx_err", {31'd0, tx_err}, 0);
        chk("rst_bad_req", {31'd0, bad_req}, 0);
        resetn = 1'b1;
        step();

        // Basic packet, then the same packet with a two-cycle stall on 0x11.
        pl = '{8'h11, 8'h22, 8'h33};
        run_pkt(2'd1, 6'd3, 1'b0, 1'b0, 0, 0, -1);
        pl = '{8'h11, 8'h22, 8'h33};
        run_pkt(2'd1, 6'd3, 1'b0, 1'b0, 0, 0, 1);

        // Error injection with router err raised.
        pl = '{8'hA5};
        run_pkt(2'd2, 6'd1, 1'b1, 1'b1, 0, 0, -1);

        // Rejected requests and start ignored under abort.
        dest = 2'd0; len = 6'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("bad_len_pulse", {31'd0, bad_req}, 1);
        chk("bad_len_idle", {31'd0, idle}, 1);
        chk("bad_len_src_ready", {31'd0, src_ready}, 0);
        step();
        chk("bad_len_once", {31'd0, bad_req}, 0);
        dest = 2'd3; len = 6'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("bad_dest_pulse", {31'd0, bad_req}, 1);
        chk("bad_dest_idle", {31'd0, idle}, 1);
        chk("bad_dest_src_ready", {31'd0, src_ready}, 0);
        dest = 2'd1; len = 6'd4; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {31'd0, idle}, 1);
        chk("start_abort_bad_req", {31'd0, bad_req}, 0);
        chk("start_abort_src_ready", {31'd0, src_ready}, 0);

        // Maximum length with alternating upstream gaps.
        fill(63);
        run_pkt(2'd0, 6'd63, 1'b0, 1'b0, 1, 0, -1);

        // Abort while payload byte 5 is on the bus.
        fill(10);
        do_start(2'd1, 6'd10, 1'b0, 1'b0);
        do_load(0);
        do_xmit(0, -1, 6, cyc);
        chk("abort_byte", {24'd0, pkt_data}, {24'd0, exp_q[6]});
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", {31'd0, pkt_valid}, 0);
        chk("abort_data", {24'd0, pkt_data}, 0);
        chk("abort_idle", {31'd0, idle}, 1);
        chk("abort_done", {31'd0, done}, 0);
        step();
        chk("abort_done_late", {31'd0, done}, 0);

        // Reset while the parity byte is on the bus.
        fill(4);
        do_start(2'd2, 6'd4, 1'b1, 1'b0);
        do_load(2);
        do_xmit(30, -1, 5, cyc);
        chk("parity_on_bus", {24'd0, pkt_data}, {24'd0, exp_q[5]});
        resetn = 1'b0;
        step();
        chk("rst_mid_valid", {31'd0, pkt_valid}, 0);
        chk("rst_mid_data", {24'd0, pkt_data}, 0);
        chk("rst_mid_idle", {31'd0, idle}, 1);
        chk("rst_mid_done", {31'd0, done}, 0);
        resetn = 1'b1;
        step();
        chk("rst_mid_done_late", {31'd0, done}, 0);

        // Randomized packets with upstream gaps and router backpressure.
        for (int p = 0; p < 8; p++) begin
            int l;
            l = $urandom_range(20, 1);
            fill(l);
            run_pkt(2'($urandom_range(2)), 6'(l), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    2, 30, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
